// File: rtl/ram_arb_pkg.sv
// Shared definitions for the program/data RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LD  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: grants the single requester, or the one not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the grant.
`timescale 1ns/1ps
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // On contention favour the index that did not win last time.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port RAM between the CPU and the program loader.
// Latency: grant in IDLE at cycle 0, ram_en at cycle 1, ack at cycle 2+RD_LAT.
// Backpressure: requesters hold req until their one-cycle ack; ld_lock starves the CPU.
`timescale 1ns/1ps
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              ld_lock,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("ram_arbiter: RD_LAT must be in 1..4");
    end
  endgenerate

  // Counter reload so that WAIT spans exactly RD_LAT cycles.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  lat_cnt;
  logic        rr_last;
  logic        gnt_valid;
  logic        gnt_idx;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;

  // The CPU drops out of arbitration entirely while the loader holds the lock.
  rr_pick2 u_pick (
    .req       ({ld_req, cpu_req & ~ld_lock}),
    .last      (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the combinational status/ack outputs.
  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    ld_ack    = 1'b0;
    case (state)
      ST_IDLE:  if (gnt_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_cnt == 2'd0) state_nxt = ST_ACK;
      ST_ACK: begin
        state_nxt = ST_IDLE;
        cpu_ack   = (owner == OWNER_CPU);
        ld_ack    = (owner == OWNER_LD);
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request latching, RAM strobes, latency counter, read capture and fairness pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= OWNER_CPU;
      rr_last     <= OWNER_LD;
      lat_cnt     <= 2'd0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_idx;
            ram_en    <= 1'b1;
            ram_we    <= (gnt_idx == OWNER_LD) ? ld_we    : cpu_we;
            ram_addr  <= (gnt_idx == OWNER_LD) ? ld_addr  : cpu_addr;
            ram_wdata <= (gnt_idx == OWNER_LD) ? ld_wdata : cpu_wdata;
          end
        end
        ST_ISSUE: lat_cnt <= LAT_LOAD;
        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (owner == OWNER_LD) ld_rdata_q  <= ram_rdata;
            else                   cpu_rdata_q <= ram_rdata;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ST_ACK:  rr_last <= owner;
        default: ;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: RD_LAT=1 instance plus an RD_LAT=3 instance.
// Expected acks are queued at stimulus time and checked by an independent monitor.
// Each instance has its own behavioural RAM with the matching read latency.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance 1 (RD_LAT = 1) ----------------
  logic       cpu_req, cpu_we, ld_req, ld_we, ld_lock;
  logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic       cpu_ack, cpu_stall, ld_ack, ram_en, ram_we, busy, owner;
  logic [7:0] cpu_rdata, ld_rdata, ram_addr, ram_wdata, ram_rdata;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  logic [7:0] mem1 [256];
  logic [7:0] pipe1;
  // One-cycle synchronous RAM for instance 1.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem1[ram_addr] <= ram_wdata;
      pipe1 <= mem1[ram_addr];
    end
  end
  assign ram_rdata = pipe1;

  // ---------------- instance 2 (RD_LAT = 3) ----------------
  logic       cpu_req2, cpu_we2, ld_req2, ld_we2, ld_lock2;
  logic [7:0] cpu_addr2, cpu_wdata2, ld_addr2, ld_wdata2;
  logic       cpu_ack2, cpu_stall2, ld_ack2, ram_en2, ram_we2, busy2, owner2;
  logic [7:0] cpu_rdata2, ld_rdata2, ram_addr2, ram_wdata2, ram_rdata2;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req2), .cpu_we(cpu_we2), .cpu_addr(cpu_addr2), .cpu_wdata(cpu_wdata2),
    .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2), .cpu_stall(cpu_stall2),
    .ld_req(ld_req2), .ld_we(ld_we2), .ld_addr(ld_addr2), .ld_wdata(ld_wdata2),
    .ld_ack(ld_ack2), .ld_rdata(ld_rdata2), .ld_lock(ld_lock2),
    .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_rdata(ram_rdata2), .busy(busy2), .owner(owner2)
  );

  logic [7:0] mem2 [256];
  logic [7:0] pipe2 [3];
  // Three-cycle synchronous RAM for instance 2.
  always @(posedge clk) begin
    if (ram_en2) begin
      if (ram_we2) mem2[ram_addr2] <= ram_wdata2;
      pipe2[0] <= mem2[ram_addr2];
    end
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end
  assign ram_rdata2 = pipe2[2];

  // ---------------- scoreboard ----------------
  typedef struct {
    bit         dut;
    bit         ld;
    bit         chk;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ack(input bit dut, input bit ld, input bit chk,
                            input logic [7:0] data, input int at);
    sb.push_back('{dut: dut, ld: ld, chk: chk, data: data, at: at});
  endtask

  task automatic on_ack(input bit dut, input bit ld, input logic [7:0] rd);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_ack: dut%0d %s ack at cycle %0d, required none",
               dut + 1, ld ? "ld" : "cpu", cyc);
    end else begin
      e = sb.pop_front();
      check("ack_source", {62'd0, dut, ld}, {62'd0, e.dut, e.ld});
      check("ack_cycle", 64'(cyc), 64'(e.at));
      if (e.chk) check("ack_rdata", {56'd0, rd}, {56'd0, e.data});
    end
  endtask

  // Monitor: every ack pulse from either instance is matched against the queue.
  always @(negedge clk) begin
    if (cpu_ack)  on_ack(1'b0, 1'b0, cpu_rdata);
    if (ld_ack)   on_ack(1'b0, 1'b1, ld_rdata);
    if (cpu_ack2) on_ack(1'b1, 1'b0, cpu_rdata2);
    if (ld_ack2)  on_ack(1'b1, 1'b1, ld_rdata2);
  end

  function automatic logic [63:0] outs1();
    return {25'd0, cpu_ack, cpu_rdata, cpu_stall, ld_ack, ld_rdata,
            ram_en, ram_we, ram_addr, ram_wdata, busy, owner};
  endfunction

  // One complete access on instance 1; returns in the IDLE cycle after the ack.
  task automatic access1(input bit ld, input bit we, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_d);
    @(posedge clk); #1;
    if (ld) begin
      ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    expect_ack(1'b0, ld, !we, exp_d, cyc + 3);
    repeat (4) @(posedge clk);
    #1;
    cpu_req = 1'b0; ld_req = 1'b0; cpu_we = 1'b0; ld_we = 1'b0;
  endtask

  int c0;

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_lock = 0;
    cpu_req2 = 0; cpu_we2 = 0; cpu_addr2 = 0; cpu_wdata2 = 0;
    ld_req2 = 0; ld_we2 = 0; ld_addr2 = 0; ld_wdata2 = 0; ld_lock2 = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    mem1[8'h10] = 8'hA5;
    mem2[8'h20] = 8'h5A;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs1(), 64'd0);
    check("reset_busy2", {63'd0, busy2}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single CPU read of 0x10.
    @(posedge clk); #1;
    c0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    expect_ack(1'b0, 1'b0, 1'b1, 8'hA5, c0 + 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rd_ram_en", {63'd0, ram_en}, {63'd0, k == 1});
      check("rd_cpu_stall", {63'd0, cpu_stall}, {63'd0, k < 3});
      if (k == 1) check("rd_ram_addr", {56'd0, ram_addr}, 64'h10);
    end
    @(posedge clk); #1 cpu_req = 1'b0;

    // Loader write 0x3C to 0x7F, then CPU reads it back.
    @(posedge clk); #1;
    c0 = cyc;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h7F; ld_wdata = 8'h3C;
    expect_ack(1'b0, 1'b1, 1'b0, 8'h00, c0 + 3);
    @(negedge clk);
    @(negedge clk);
    check("wr_issue_strobes", {62'd0, ram_en, ram_we}, 64'd3);
    check("wr_issue_addr_data", {48'd0, ram_addr, ram_wdata}, 64'h7F3C);
    repeat (3) @(posedge clk);
    #1 ld_req = 1'b0; ld_we = 1'b0;
    access1(1'b0, 1'b0, 8'h7F, 8'h00, 8'h3C);

    // Both requesting continuously right after reset: CPU, LD, CPU, LD every 4 cycles.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    cpu_req = 1'b1; cpu_addr = 8'h10; ld_req = 1'b1; ld_addr = 8'h7F;
    expect_ack(1'b0, 1'b0, 1'b1, 8'hA5, c0 + 3);
    expect_ack(1'b0, 1'b1, 1'b1, 8'h3C, c0 + 7);
    expect_ack(1'b0, 1'b0, 1'b1, 8'hA5, c0 + 11);
    expect_ack(1'b0, 1'b1, 1'b1, 8'h3C, c0 + 15);
    repeat (16) @(posedge clk);
    #1 cpu_req = 1'b0; ld_req = 1'b0;

    // Loader lock: only the loader is served until the lock drops.
    @(posedge clk); #1;
    c0 = cyc;
    ld_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 8'h10; ld_req = 1'b1; ld_addr = 8'h7F;
    expect_ack(1'b0, 1'b1, 1'b1, 8'h3C, c0 + 3);
    expect_ack(1'b0, 1'b1, 1'b1, 8'h3C, c0 + 7);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lock_cpu_stall", {63'd0, cpu_stall}, 64'd1);
    end
    @(posedge clk); #1;
    ld_lock = 1'b0; ld_req = 1'b0;
    expect_ack(1'b0, 1'b0, 1'b1, 8'hA5, c0 + 11);
    repeat (4) @(posedge clk);
    #1 cpu_req = 1'b0;

    // Reset during WAIT of a loader read: access is dropped, outputs clear.
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h7F;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_owner_busy", {62'd0, owner, busy}, 64'd3);
    @(posedge clk); #1;
    reset = 1'b1; ld_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", outs1(), 64'd0);
    access1(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
    @(negedge clk);
    check("post_abort_owner", {63'd0, owner}, 64'd0);

    // RD_LAT = 3 instance, loader read: ram_en at cycle 1, ld_ack at cycle 5.
    @(posedge clk); #1;
    c0 = cyc;
    ld_req2 = 1'b1; ld_we2 = 1'b0; ld_addr2 = 8'h20;
    expect_ack(1'b1, 1'b1, 1'b1, 8'h5A, c0 + 5);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lat3_ram_en", {63'd0, ram_en2}, {63'd0, k == 1});
    end
    @(posedge clk); #1 ld_req2 = 1'b0;

    // Drain: every queued ack must have been seen within a bounded window.
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL missing_ack: %0d acks outstanding, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Arbitrates one single-port synchronous program/data RAM between two requesters: the CPU (instruction fetch into the control unit's IR, and data transfers) and the program loader (external programming and debug port).
- Sits between the CPU bus/control unit and the RAM macro.
- Each access is sequenced as an issue cycle, a programmable read-latency wait, and a one-cycle acknowledge.
- Round-robin fairness applies, with a loader-exclusive lock mode for programming.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata. Legal range is 1..4; any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack is high.
- cpu_stall  out  1  cpu_req high and no cpu_ack this cycle (combinational); gates the CPU step counter.
- ld_req  in  1  loader request, same rules as cpu_req.
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ack  out  1  one-cycle completion pulse.
- ld_rdata  out  DATA_W  loader read data, valid when ld_ack is high.
- ld_lock  in  1  while high, the CPU is never granted.
- ram_en  out  1  RAM access strobe, registered.
- ram_we  out  1  RAM write strobe, registered; high only together with ram_en.
- ram_addr  out  ADDR_W  registered address.
- ram_wdata  out  DATA_W  registered write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  state is not IDLE.
- owner  out  1  current or last grant; 0 = CPU, 1 = loader.

Behaviour:
- Reset values: all outputs 0, state IDLE, owner 0, rr_last 1 (CPU is favoured first), latency counter 0.
- FSM IDLE:
  - Evaluate eligible requests. cpu_req is eligible only when ld_lock = 0; ld_req is always eligible.
  - One eligible request: grant it.
  - Both eligible: grant the requester not equal to rr_last.
  - On grant: latch owner, we, addr and wdata into the ram_* registers and go to ISSUE.
  - No eligible request: stay in IDLE.
- FSM ISSUE (1 cycle):
  - ram_en = 1; ram_we = latched we.
  - Next state is WAIT. The counter loads RD_LAT-1.
- FSM WAIT:
  - ram_en = 0.
  - Decrement the counter each cycle.
  - When the counter is 0, capture ram_rdata into the owner's rdata register and go to ACK.
  - With RD_LAT = 1, WAIT lasts exactly one cycle.
- FSM ACK (1 cycle):
  - Pulse the owner's ack.
  - rr_last <= owner.
  - Return to IDLE.
- Latency: request first seen in IDLE at cycle 0 gives ram_en at cycle 1 and ack at cycle 2+RD_LAT.
  - With RD_LAT = 1, ack is at cycle 3.
  - Back-to-back throughput is one access per 3+RD_LAT cycles.
  - Writes use the same timing as reads; rdata is captured regardless of access type and is don't-care for writes.
- Requester rule: deassert req in the cycle after ack. A req still high in the following IDLE cycle is a new access.
- Request changing or dropping before its ack is a protocol violation. The arbiter ignores it: it has already latched the request, and the ack is still issued.
- ld_lock rising mid-access does not abort a CPU access in flight. The lock takes effect at the next IDLE arbitration.
- Simultaneous requests:
  - cpu and ld both requesting, rr_last = 1: CPU wins.
  - With both continuously requesting, grants alternate strictly.
- Inactive rdata registers hold their last value.
- Reset asserted in any state:
  - Next cycle state is IDLE and all outputs are 0.
  - The pending access is dropped with no ack. Any RAM write already strobed is not undone.

Decomposition:
- Shared package ram_arb_pkg:
  - state encoding constants ST_IDLE = 0, ST_ISSUE = 1, ST_WAIT = 2, ST_ACK = 3;
  - OWNER_CPU = 0, OWNER_LD = 1.
- Sub-module rr_pick2: a combinational 2-way round-robin selector.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_idx.
  - Also reusable for later bus arbiters.

Test Plan:
- Single CPU read, RD_LAT = 1, RAM preset so [0x10] = 0xA5:
  - cpu_req at cycle 0 with addr 0x10 -> ram_en = 1 at cycle 1 only, ram_addr = 0x10;
  - cpu_ack at cycle 3 with cpu_rdata = 0xA5;
  - cpu_stall is high at cycles 0..2.
- Loader write 0x3C to 0x7F, then CPU read of 0x7F:
  - write: ram_we = 1 at ISSUE, then ld_ack;
  - read: cpu_rdata = 0x3C.
- Both requesting continuously from reset, 4 accesses:
  - grant order CPU, LD, CPU, LD;
  - one ack per 4 cycles.
- ld_lock = 1 with both requesting:
  - only ld_ack pulses;
  - cpu_stall stays 1;
  - dropping ld_lock allows the CPU to be granted at the next IDLE.
- RD_LAT = 3 build, loader read: ram_en at cycle 1, ld_ack at cycle 5.
- Reset asserted during WAIT:
  - no ack is ever produced for that access;
  - all outputs read 0 the next cycle;
  - a fresh cpu_req then completes normally and owner = 0.
